// File: rtl/seq_pattern_tx_if.sv
// Job-request and serial-output bundle for seq_pattern_tx.
// repeat_cnt carries the repeat count; "repeat" itself is a reserved word.
interface seq_pattern_tx_if #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned GAP_W = 4
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] repeat_cnt;
    logic [GAP_W-1:0] gap;
    logic             out;
    logic             out_valid;
    logic             frame_last;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pattern, len, repeat_cnt, gap,
        input  out, out_valid, frame_last, busy, done
    );

    modport slave (
        input  start, abort, pattern, len, repeat_cnt, gap,
        output out, out_valid, frame_last, busy, done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, repeat+1 frames with
// gap idle cycles between frames. All outputs come straight from flops.
module seq_pattern_tx #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned GAP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    seq_pattern_tx_if.slave    bus
);
    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] frames_q, frames_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] len_clamped;
    logic [PAT_W-1:0] pat_shift;

    always_comb begin
        len_clamped = bus.len;
        if (bus.len == '0 || bus.len > LEN_W'(PAT_W)) len_clamped = LEN_W'(PAT_W);
    end

    // Output flops are loaded with the value for the cycle being entered, so the
    // first bit shows up in the cycle right after the accepting edge.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        idx_d     = idx_q;
        frames_d  = frames_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.abort) begin
                    pat_d    = bus.pattern;
                    len_d    = len_clamped;
                    frames_d = bus.repeat_cnt;
                    gap_d    = bus.gap;
                    idx_d    = len_clamped - LEN_W'(1);
                    state_d  = StSend;
                    valid_d  = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            StSend: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (idx_q != '0) begin
                    idx_d   = idx_q - LEN_W'(1);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (frames_q == '0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    frames_d = frames_q - CNT_W'(1);
                    busy_d   = 1'b1;
                    if (gap_q == '0) begin
                        idx_d   = len_q - LEN_W'(1);
                        valid_d = 1'b1;
                    end else begin
                        state_d   = StGap;
                        gap_cnt_d = gap_q - GAP_W'(1);
                    end
                end
            end
            StGap: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else begin
                    busy_d = 1'b1;
                    if (gap_cnt_q == '0) begin
                        state_d = StSend;
                        idx_d   = len_q - LEN_W'(1);
                        valid_d = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q - GAP_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        pat_shift = pat_d >> idx_d;
        out_d     = valid_d & pat_shift[0];
        last_d    = valid_d && (idx_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pat_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            frames_q  <= '0;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            out_q     <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            frames_q  <= frames_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.out        = out_q;
    assign bus.out_valid  = valid_q;
    assign bus.frame_last = last_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx; expected streams come from a frame-level model
// that lists, per cycle, {out_valid, out, frame_last, busy, done}.
module tb_seq_pattern_tx;
    localparam int unsigned PAT_W = 8;
    localparam int unsigned LEN_W = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned GAP_W = 4;

    typedef struct packed {
        logic v;
        logic o;
        logic l;
        logic b;
        logic d;
    } rec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    rec_t exp_q[$];
    rec_t got_q[$];

    seq_pattern_tx_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

    seq_pattern_tx #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic rec_t sample();
        rec_t r;
        r = '{bus.out_valid, bus.out, bus.frame_last, bus.busy, bus.done};
        return r;
    endfunction

    // Appends one complete job (all frames, gaps and the done cycle) to exp_q.
    function automatic void model_job(input logic [7:0] pat, input int len, input int rep,
                                      input int gap);
        int clen;
        clen = (len == 0 || len > 8) ? 8 : len;
        for (int f = 0; f <= rep; f++) begin
            for (int b = clen - 1; b >= 0; b--) exp_q.push_back('{1'b1, pat[b], b == 0, 1'b1, 1'b0});
            if (f < rep) for (int g = 0; g < gap; g++) exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
        end
        exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    endfunction

    task automatic launch(input logic [7:0] pat, input int len, input int rep, input int gap);
        bus.pattern    = pat;
        bus.len        = LEN_W'(len);
        bus.repeat_cnt = CNT_W'(rep);
        bus.gap        = GAP_W'(gap);
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic capture(input int n);
        got_q.delete();
        got_q.push_back(sample());
        for (int i = 1; i < n; i++) begin
            @(posedge clk);
            #1;
            got_q.push_back(sample());
        end
    endtask

    task automatic test_reset();
        rec_t r;
        #1;
        r = sample();
        n_checks++;
        if (r !== rec_t'('0)) begin
            n_fail++;
            $display("FAIL reset_assert: got %b required 00000", r);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            r = sample();
            n_checks++;
            if (r !== rec_t'('0)) begin
                n_fail++;
                $display("FAIL reset_idle: cycle %0d got %b required 00000", i, r);
            end
        end
    endtask

    task automatic test_basic();
        exp_q.delete();
        model_job(8'h07, 3, 0, 0);
        launch(8'h07, 3, 0, 0);
        capture(exp_q.size());
        foreach (exp_q[i]) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic: cycle %0d got %b required %b", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_gap();
        int nv, nb, nd;
        exp_q.delete();
        model_job(8'h0A, 4, 2, 2);
        launch(8'h0A, 4, 2, 2);
        capture(exp_q.size());
        nv = 0; nb = 0; nd = 0;
        foreach (exp_q[i]) begin
            nv += int'(got_q[i].v);
            nb += int'(got_q[i].b);
            nd += int'(got_q[i].d);
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL gap_stream: cycle %0d got %b required %b", i, got_q[i], exp_q[i]);
            end
        end
        n_checks += 3;
        if (nv != 12) begin n_fail++; $display("FAIL gap_valid_count: got %0d required 12", nv); end
        if (nb != 16) begin n_fail++; $display("FAIL gap_busy_count: got %0d required 16", nb); end
        if (nd != 1) begin n_fail++; $display("FAIL gap_done_count: got %0d required 1", nd); end
    endtask

    task automatic test_clamp();
        int lens[2];
        lens[0] = 0;
        lens[1] = 15;
        foreach (lens[k]) begin
            exp_q.delete();
            model_job(8'hA5, 8, 0, 0);
            launch(8'hA5, lens[k], 0, 0);
            capture(exp_q.size());
            foreach (exp_q[i]) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL clamp_len%0d: cycle %0d got %b required %b", lens[k], i,
                             got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_ignore_start();
        int n1, total;
        exp_q.delete();
        model_job(8'h5A, 8, 1, 1);
        n1 = exp_q.size();
        model_job(8'hC3, 5, 0, 0);
        total = exp_q.size();
        launch(8'h5A, 8, 1, 1);
        got_q.delete();
        for (int i = 0; i < total; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            got_q.push_back(sample());
            if (i == 2) begin
                bus.start   = 1'b1;
                bus.pattern = 8'hFF;
                bus.len     = LEN_W'(3);
            end
            if (i == 3) bus.start = 1'b0;
            if (i == 5) begin
                bus.start      = 1'b1;
                bus.pattern    = 8'hC3;
                bus.len        = LEN_W'(5);
                bus.repeat_cnt = '0;
                bus.gap        = '0;
            end
            if (i == n1) bus.start = 1'b0;
        end
        foreach (exp_q[i]) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL ignore_start: cycle %0d got %b required %b", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_abort();
        rec_t r;
        launch(8'h0B, 4, 3, 1);
        r = sample();
        n_checks++;
        if (r !== 5'b11010) begin n_fail++; $display("FAIL abort_bit1: got %b required 11010", r); end
        @(posedge clk);
        #1;
        r = sample();
        n_checks++;
        if (r !== 5'b10010) begin n_fail++; $display("FAIL abort_bit2: got %b required 10010", r); end
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            r = sample();
            n_checks++;
            if (r !== rec_t'('0)) begin
                n_fail++;
                $display("FAIL abort_after: cycle %0d got %b required 00000", i, r);
            end
            @(posedge clk);
            #1;
        end
        // abort in IDLE must block a simultaneous start
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        r = sample();
        n_checks++;
        if (r !== rec_t'('0)) begin n_fail++; $display("FAIL abort_idle: got %b required 00000", r); end
        exp_q.delete();
        model_job(8'h36, 6, 1, 0);
        launch(8'h36, 6, 1, 0);
        capture(exp_q.size());
        foreach (exp_q[i]) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL abort_restart: cycle %0d got %b required %b", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_gap();
        rec_t r;
        launch(8'h03, 2, 2, 4);
        capture(4);
        n_checks++;
        if (got_q[3] !== 5'b00010) begin
            n_fail++;
            $display("FAIL rst_in_gap: got %b required 00010", got_q[3]);
        end
        #2;
        rst = 1'b1;
        #1;
        r = sample();
        n_checks++;
        if (r !== rec_t'('0)) begin n_fail++; $display("FAIL rst_async: got %b required 00000", r); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            r = sample();
            n_checks++;
            if (r !== rec_t'('0)) begin
                n_fail++;
                $display("FAIL rst_hold: cycle %0d got %b required 00000", i, r);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] pat;
        int len, rep, gap;
        for (int j = 0; j < 20; j++) begin
            pat = 8'($urandom);
            len = int'($urandom_range(0, 15));
            rep = int'($urandom_range(0, 3));
            gap = int'($urandom_range(0, 3));
            exp_q.delete();
            model_job(pat, len, rep, gap);
            launch(pat, len, rep, gap);
            capture(exp_q.size());
            foreach (exp_q[i]) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL random_job%0d: pat=%h len=%0d rep=%0d gap=%0d cycle %0d got %b required %b",
                             j, pat, len, rep, gap, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.pattern    = '0;
        bus.len        = '0;
        bus.repeat_cnt = '0;
        bus.gap        = '0;
        test_reset();
        test_basic();
        test_gap();
        test_clamp();
        test_ignore_start();
        test_abort();
        test_reset_mid_gap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
